// File: rtl/pll_rst_seq_pkg.sv
// Shared types and widths for the PLL reset/lock sequencer.
// Widths derive from the largest cycle count the counter must reach.
package pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } seq_state_e;

    // Counter only has to reach (max - 1), so clog2(max) bits suffice.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int CNT_W    = cnt_width(16, 1024, 50000);
    localparam int RELOCK_W = 8;

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// N-stage single-bit synchronizer for an asynchronous level input.
// Latency N cycles; no backpressure. N must be at least 2.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] stage_q;
    logic [N-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock, releases sys_rst_n.
// Outputs are registered from the next state, so they move on the transition edge.
module pll_reset_sequencer
    import pll_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                locked,
    output logic                pll_rst,
    output logic                sys_rst_n,
    output logic                locked_sync,
    output logic                pll_fault,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int CW     = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int FAIL_W = ($clog2(MAX_RETRIES + 1) > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    seq_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_rst_n_q, sys_rst_n_d;
    logic                pll_fault_q, pll_fault_d;
    logic                lock_s;

    sync_ff #(
        .N (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst),
        .d     (locked),
        .q     (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        fail_d   = fail_q;
        relock_d = relock_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock coinciding with the timeout wins; no retry is charged.
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    if (fail_q == FAIL_W'(MAX_RETRIES)) begin
                        state_d = FAULT;
                    end else begin
                        fail_d  = fail_q + FAIL_W'(1);
                        state_d = PLL_RST;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d  = '0;
                fail_d = '0;
                if (!lock_s) begin
                    state_d = PLL_RST;
                    if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
                end
            end
            FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;

        pll_rst_d   = (state_d == PLL_RST) || (state_d == FAULT);
        sys_rst_n_d = (state_d == RUN);
        pll_fault_d = (state_d == FAULT);
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            fail_q      <= '0;
            relock_q    <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fail_q      <= fail_d;
            relock_q    <= relock_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            pll_fault_q <= pll_fault_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst_n    = sys_rst_n_q;
    assign locked_sync  = lock_s;
    assign pll_fault    = pll_fault_q;
    assign relock_count = relock_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor for the clock-generation PLL, on the opposite side of its reset/lock interface: it drives the PLL's active-high `rst` and consumes its asynchronous `locked`. It releases the design-wide system reset only after lock has been continuously stable for a qualification window. On lock loss it re-resets the PLL, retries failed lock attempts a bounded number of times, then latches a fault. It runs on the PLL reference clock and sits between the board reset and every core that is clocked from `outclk_0`.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `locked`; must be ≥ 2.
- `PLL_RST_CYCLES`, 16: width of each `pll_rst` pulse, in cycles.
- `LOCK_STABLE_CYCLES`, 1024: cycles of continuous lock required before `sys_rst_n` is released.
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles to wait for lock after `pll_rst` falls (1 ms at 50 MHz).
- `MAX_RETRIES`, 3: PLL re-reset attempts allowed after a timeout before a fault is declared.
- `refclk` in 1: reference clock. Single clock domain.
- `rst` in 1: reset. Synchronous, active-low.
- `locked` in 1: PLL lock indication. Asynchronous to `refclk`.
- `pll_rst` out 1: active-high reset to the PLL.
- `sys_rst_n` out 1: active-low system reset.
- `locked_sync` out 1: synchronized `locked`.
- `pll_fault` out 1: sticky flag; retries are exhausted.
- `relock_count` out 8: saturating count of lock losses that occurred in RUN.

## Operation
- `locked` passes through a `SYNC_STAGES`-flop synchronizer. The last stage is `locked_sync`. The FSM sees only `locked_sync`.
- One shared cycle counter `cnt` is cleared on every state entry.
- The FSM has five states:
  - PLL_RST: `pll_rst`=1, `sys_rst_n`=0. When `cnt`==`PLL_RST_CYCLES`-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0. If `locked_sync`=1, go to STABLE. Otherwise, when `cnt`==`LOCK_TIMEOUT_CYCLES`-1:
    - if `fail_cnt`==`MAX_RETRIES`, go to FAULT;
    - else increment `fail_cnt` and go to PLL_RST.
  - STABLE: if `locked_sync`=0, go to WAIT_LOCK (timeout restarts, `fail_cnt` unchanged). When `cnt`==`LOCK_STABLE_CYCLES`-1 with `locked_sync`=1, go to RUN.
  - RUN: `sys_rst_n`=1 and `fail_cnt` is cleared. If `locked_sync`=0, go to PLL_RST and increment `relock_count` (saturates at 255).
  - FAULT: `pll_rst`=1, `sys_rst_n`=0, `pll_fault`=1. Exit only via `rst`.
- Simultaneous events: lock arriving in the same cycle as the timeout is treated as lock (go to STABLE, no retry is counted).
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state transition.

## Timing
- While `rst`=0, every output and all state take their reset values on the next edge:
  - `pll_rst`=1, `sys_rst_n`=0, `locked_sync`=0, `pll_fault`=0, `relock_count`=0;
  - state=PLL_RST, `cnt`=0, `fail_cnt`=0, synchronizer flops=0.
- `rst` asserted mid-operation (any state, including FAULT) aborts immediately with the same values.
- After `rst` is released, `pll_rst` stays high for exactly `PLL_RST_CYCLES` edges.
- Lock qualification: let edge k be the first edge that samples `locked`=1.
  - `locked_sync` rises at edge k+`SYNC_STAGES`-1.
  - STABLE is entered at edge k+`SYNC_STAGES`.
  - `sys_rst_n` rises at edge k+`SYNC_STAGES`+`LOCK_STABLE_CYCLES`.
- Lock loss in RUN: if the first edge sampling `locked`=0 is edge j, then `sys_rst_n` falls, `pll_rst` rises and `relock_count` increments at edge j+`SYNC_STAGES`.
- Never-locking PLL: it receives `MAX_RETRIES`+1 `pll_rst` pulses. FAULT is entered on the edge ending the final timeout.

## Structure
- Shared package `pll_rst_seq_pkg` holds:
  - the state enum `{PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT}`;
  - `CNT_W` = `$clog2` of the largest of the three cycle parameters;
  - `RELOCK_W` = 8.
- One sub-module: `sync_ff`, a parameterized N-stage single-bit synchronizer. The FSM, counters and output registers live in the top module.

## Test plan
All scenarios use `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=20, `MAX_RETRIES`=2, `SYNC_STAGES`=2. The PLL model raises `locked` 10 cycles after `pll_rst` falls unless stated otherwise.
- Power-up: release `rst` -> `pll_rst` is high for exactly 4 edges; `sys_rst_n` rises exactly 10 edges after the first edge sampling `locked`=1.
- STABLE glitch: drop `locked` for 1 cycle while `cnt`=5 -> `sys_rst_n` stays 0; it rises 10 edges after the edge that re-samples `locked`=1; `relock_count`=0.
- Loss in RUN: drop `locked` -> 2 edges later `sys_rst_n`=0, `pll_rst`=1, `relock_count`=1; then a full re-sequence to RUN completes.
- Never lock: hold `locked`=0 -> 3 `pll_rst` pulses; `pll_fault`=1 after the 3rd 20-cycle timeout; `pll_rst` is held at 1; asserting `locked` afterwards has no effect.
- Reset mid-RUN and in FAULT: `rst`=0 for 1 cycle -> next edge, all outputs are at reset values, `relock_count`=0, `pll_fault`=0.
- Saturation: force 260 lock losses in RUN -> `relock_count` reads 255 and stays there.
